seg_serial_shifter: RTL

Downstream stage of the 8-digit hex-to-segment converter. It captures the 64-bit segment image (8 digits × {a,b,c,d,e,f,g,p}) and shifts it bit-serially into the board's cascaded 74HC164-style segment shift registers. It generates the serial clock, the data line and the output-enable/latch strobe, and handshakes with the refresh controller via start/busy/done.

---
 rtl/seg_pkg.sv | 6 +
 rtl/seg_serial_shifter_if.sv | 13 +
 rtl/seg_phase_div.sv | 16 +
 rtl/seg_serial_shifter.sv | 87 ++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the segment serial shifter
package seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} seg_state_e;
  localparam int SEG_FRAME_BITS = 64;
  localparam int SEG_DIGITS = 8;
endpackage

// File: rtl/seg_serial_shifter_if.sv
// seg_serial_shifter_if: frame handshake and board-side serial lines
interface seg_serial_shifter_if import seg_pkg::*; #(parameter int DATA_BITS = SEG_FRAME_BITS);
  logic start;
  logic [DATA_BITS-1:0] seg_txt;
  logic busy;
  logic done;
  logic seg_clk;
  logic seg_sout;
  logic seg_pen;
  logic seg_clrn;
  modport master(output start, seg_txt, input busy, done, seg_clk, seg_sout, seg_pen, seg_clrn);
  modport slave(input start, seg_txt, output busy, done, seg_clk, seg_sout, seg_pen, seg_clrn);
endinterface

// File: rtl/seg_phase_div.sv
// seg_phase_div: bit-period phase counter with mid-bit and end-of-bit ticks
module seg_phase_div #(parameter int CLK_DIV = 2) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic bit_tick
);
  localparam int PW = $clog2(2 * CLK_DIV);
  logic [PW-1:0] phase_q, phase_d;
  assign half_tick = en && phase_q == PW'(CLK_DIV - 1);
  assign bit_tick = en && phase_q == PW'(2 * CLK_DIV - 1);
  always_comb phase_d = (clr || bit_tick) ? '0 : en ? phase_q + PW'(1) : phase_q;
  always_ff @(posedge clk) phase_q <= rst ? '0 : phase_d;
endmodule

// File: rtl/seg_serial_shifter.sv
// seg_serial_shifter: shifts a 64-bit segment image MSB-first into cascaded 74HC164 registers
module seg_serial_shifter import seg_pkg::*; #(
  parameter int DATA_BITS = SEG_FRAME_BITS,
  parameter int CLK_DIV = 2
) (
  input logic clk,
  input logic rst,
  seg_serial_shifter_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  seg_state_e state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, sout_q, sout_d, pen_q, pen_d;
  logic load, half_tick, bit_tick;
  seg_phase_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk), .rst(rst), .clr(load), .en(state_q != IDLE),
    .half_tick(half_tick), .bit_tick(bit_tick)
  );
  // outputs are registered and set from the transition that leads into each phase
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    sclk_d = sclk_q;
    sout_d = sout_q;
    pen_d = pen_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        load = 1'b1;
        state_d = SHIFT;
        sr_d = bus.seg_txt;
        cnt_d = CW'(DATA_BITS);
        busy_d = 1'b1;
        sclk_d = 1'b0;
        sout_d = bus.seg_txt[DATA_BITS-1];
        pen_d = 1'b0;
      end
      SHIFT: begin
        sclk_d = bit_tick ? 1'b0 : half_tick ? 1'b1 : sclk_q;
        if (bit_tick) begin
          sr_d = sr_q << 1;
          cnt_d = cnt_q - CW'(1);
          sout_d = cnt_q == CW'(1) ? 1'b0 : sr_q[DATA_BITS-2];
          pen_d = cnt_q == CW'(1);
          state_d = cnt_q == CW'(1) ? LATCH : SHIFT;
        end
      end
      LATCH: if (half_tick) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      sout_q <= 1'b0;
      pen_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sclk_q <= sclk_d;
      sout_q <= sout_d;
      pen_q <= pen_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.seg_clk = sclk_q;
  assign bus.seg_sout = sout_q;
  assign bus.seg_pen = pen_q;
  assign bus.seg_clrn = ~rst;
endmodule
